// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues in-order imem reads and buffers words.
// Optional perf counters via FETCH_PERF_EN (perf_fetched, perf_stall).
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  output logic [31:0] if_pc
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int DROP_W = 16;
  localparam logic [CNT_W:0] DEPTH_S =
    (CNT_W+1)'(FIFO_DEPTH);

  logic [31:0]       r_pc;
  logic [CNT_W-1:0]  r_out;
  logic [DROP_W-1:0] r_drop;
  logic [CNT_W-1:0]  r_cnt;
  logic [PTR_W-1:0]  r_wp;
  logic [PTR_W-1:0]  r_rp;
  logic [PTR_W-1:0]  r_qwp;
  logic [PTR_W-1:0]  r_qrp;
  logic [31:0]       r_instr [FIFO_DEPTH];
  logic [31:0]       r_fpc   [FIFO_DEPTH];
  logic [31:0]       r_qpc   [FIFO_DEPTH];

  logic [CNT_W:0]    w_sum;
  logic              w_req_v;
  logic              w_req_fire;
  logic              w_is_drop;
  logic              w_rsp_live;
  logic              w_rsp_any;
  logic              w_push;
  logic              w_pop;
  logic              w_if_valid;
  logic [31:0]       w_redir_pc;
  logic [31:0]       w_pc_nxt;

  // Slots are reserved at request time so the FIFO can never overflow.
  assign w_sum      = {1'b0, r_cnt} + {1'b0, r_out};
  assign w_req_v    = !rst && !redirect_valid
                    && (w_sum < DEPTH_S);
  assign w_req_fire = w_req_v && imem_req_ready;

  // Responses are in order: stale words always precede live ones.
  assign w_is_drop  = imem_rsp_valid && (r_drop != '0);
  assign w_rsp_live = imem_rsp_valid && (r_drop == '0)
                    && (r_out != '0);
  assign w_rsp_any  = w_is_drop || w_rsp_live;
  assign w_push     = w_rsp_live && !redirect_valid;

  assign w_if_valid = !rst && (r_cnt != '0);
  assign w_pop      = w_if_valid && if_ready
                    && !redirect_valid;
  assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;

  assign imem_req_valid = w_req_v;
  assign imem_req_addr  = rst ? RESET_PC : r_pc;
  assign if_valid       = w_if_valid;
  assign if_instr       = w_if_valid ? r_instr[r_rp] : '0;
  assign if_pc          = w_if_valid ? r_fpc[r_rp]   : '0;

  // Next fetch PC: redirect target or sequential advance.
  always_comb begin
    w_pc_nxt = r_pc;
    unique case (1'b1)
      redirect_valid: w_pc_nxt = w_redir_pc;
      w_req_fire:     w_pc_nxt = r_pc + 32'd4;
      default:        w_pc_nxt = r_pc;
    endcase
  end

  // PC register.
  always_ff @(posedge clk) begin
    if (rst) r_pc <= RESET_PC;
    else     r_pc <= w_pc_nxt;
  end

  // Outstanding and drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_drop <= '0;
    end else if (redirect_valid) begin
      r_out  <= '0;
      r_drop <= r_drop + DROP_W'(r_out)
              - DROP_W'(w_rsp_any);
    end else begin
      r_out <= r_out + CNT_W'(w_req_fire)
             - CNT_W'(w_rsp_live);
      if (w_is_drop) r_drop <= r_drop - DROP_W'(1);
    end
  end

  // Pointers of the PC queue for live in-flight requests.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      r_qwp <= '0;
      r_qrp <= '0;
    end else begin
      if (w_req_fire) r_qwp <= r_qwp + PTR_W'(1);
      if (w_rsp_live) r_qrp <= r_qrp + PTR_W'(1);
    end
  end

  // PC queue storage.
  always_ff @(posedge clk) begin
    if (w_req_fire) r_qpc[r_qwp] <= r_pc;
  end

  // Fetch buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + PTR_W'(1);
      if (w_pop)  r_rp <= r_rp + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_push)
             - CNT_W'(w_pop);
    end
  end

  // Fetch buffer storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wp] <= imem_rsp_data;
      r_fpc[r_wp]   <= r_qpc[r_qrp];
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;

  // Delivered words and empty-output cycles; redirect does not clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_pop)       r_perf_fetched <= r_perf_fetched + 32'd1;
      if (!w_if_valid) r_perf_stall   <= r_perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: fixed-latency memory model plus a PC scoreboard.
// Expected PCs are queued on request acceptance, checked on delivery.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] K        = 32'hA5A5_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
`ifdef FETCH_PERF_EN
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall),
`endif
    .if_pc          (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] sb[$];
  logic [31:0] req_pc;
  logic [31:0] held_addr;
  logic        held;
  int          checks;
  int          errors;
  int          cyc;
  int          lat;
  int          n_acc;
  int          n_del;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] e;
    mreq_t       m;
    @(negedge clk);
    if (!rst) begin
      if (if_valid && if_ready && !redirect_valid) begin
        n_del++;
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_out: observed pc %h expected none",
                 if_pc);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("if_pc", if_pc, e);
          chk("if_instr", if_instr, e ^ K);
        end
      end
      if (redirect_valid) begin
        chk("req_in_redirect", 32'(imem_req_valid), 32'd0);
        sb.delete();
        req_pc = redirect_pc & 32'hFFFF_FFFC;
        held   = 1'b0;
      end
      if (imem_req_valid) begin
        if (held) chk("addr_held", imem_req_addr, held_addr);
        if (imem_req_ready) begin
          chk("req_addr", imem_req_addr, req_pc);
          m.due  = cyc + lat;
          m.addr = imem_req_addr;
          mq.push_back(m);
          sb.push_back(req_pc);
          req_pc = req_pc + 32'd4;
          n_acc++;
          held = 1'b0;
        end else begin
          held      = 1'b1;
          held_addr = imem_req_addr;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else if (mq.size() != 0 && mq[0].due == cyc) begin
      m = mq.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = m.addr ^ K;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    tick();
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'd0);
    chk("rst_perf_stall", perf_stall, 32'd0);
`endif
    tick();
    rst = 1'b0;
    sb.delete();
    req_pc = RESET_PC;
    n_acc  = 0;
    n_del  = 0;
    held   = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!if_valid && k < 30) begin
      tick();
      k++;
    end
    checks++;
    assert (if_valid) else begin
      errors++;
      $error("FAIL wait_valid: observed timeout expected if_valid");
    end
  endtask

  initial begin
    int d0;
    int k;
    checks         = 0;
    errors         = 0;
    cyc            = 0;
    lat            = 1;
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b1;
    held           = 1'b0;
    req_pc         = RESET_PC;

    // streaming, one per cycle
    do_reset();
    repeat (5) tick();
    d0 = n_del;
    repeat (16) tick();
    chk("no_gaps", 32'(n_del - d0), 32'd16);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'(n_del));
    chk("perf_stall", perf_stall, 32'd2);
`endif

    // decode stalled from reset
    if_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    chk("full_acc", 32'(n_acc), 32'd4);
    chk("full_req_valid", 32'(imem_req_valid), 32'd0);
    chk("full_if_pc", if_pc, 32'h0);
    if_ready = 1'b1;
    repeat (8) tick();
    chk("resume", 32'(n_del >= 5), 32'd1);

    // memory request backpressure
    do_reset();
    for (int i = 0; i < 30; i++) begin
      imem_req_ready = (i % 3) != 0;
      tick();
    end
    imem_req_ready = 1'b1;
    repeat (6) tick();
    chk("bp_delivered", 32'(n_del > 10), 32'd1);

    // redirect with two responses in flight, 3-cycle memory
    lat = 3;
    do_reset();
    k = 0;
    while (n_acc < 2 && k < 10) begin
      tick();
      k++;
    end
    chk("two_acc", 32'(n_acc), 32'd2);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    wait_valid(k);
    chk("redir_lat3", 32'(k + 1), 32'd5);
    chk("redir_pc", if_pc, 32'h0000_0100);
    repeat (6) tick();

    // redirect colliding with pop and response, 1-cycle memory
    lat = 1;
    do_reset();
    repeat (8) tick();
    chk("pre_if_valid", 32'(if_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h2000_0040;
    tick();
    redirect_valid = 1'b0;
    chk("post_redir_empty", 32'(if_valid), 32'd0);
    wait_valid(k);
    chk("redir_lat1", 32'(k + 1), 32'd3);
    chk("redir_pc2", if_pc, 32'h2000_0040);
    repeat (4) tick();

    // back-to-back redirects, 2-cycle memory
    lat = 2;
    do_reset();
    repeat (6) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    tick();
    redirect_pc    = 32'h0000_0402;
    tick();
    redirect_valid = 1'b0;
    wait_valid(k);
    chk("b2b_lat", 32'(k + 1), 32'd4);
    chk("b2b_pc", if_pc, 32'h0000_0400);
    repeat (6) tick();

    // reset with the buffer full
    lat      = 1;
    if_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    chk("full_valid", 32'(if_valid), 32'd1);
    do_reset();
    if_ready = 1'b1;
    repeat (6) tick();
    chk("after_rst_run", 32'(n_del > 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
